// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: scheduler state encoding,
// default acceptance timeout and the baud-rate select codes.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD        = 2'd1,
        WAIT_ACCEPT = 2'd2,
        WAIT_DONE   = 2'd3
    } sched_state_t;

    localparam int DEFAULT_ACCEPT_TIMEOUT = 16;

    localparam logic [1:0] BAUD_SEL_9600   = 2'd0;
    localparam logic [1:0] BAUD_SEL_19200  = 2'd1;
    localparam logic [1:0] BAUD_SEL_57600  = 2'd2;
    localparam logic [1:0] BAUD_SEL_115200 = 2'd3;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    localparam int W1 = IDX_W + 1;

    logic [W1-1:0] w_cand;

    // Walk the offsets from farthest to nearest so the closest request to the pointer wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, i_ptr} + W1'(k);
            if (w_cand >= W1'(NUM_REQ)) begin
                w_cand = w_cand - W1'(NUM_REQ);
            end
            if (i_req[w_cand[IDX_W-1:0]]) begin
                o_grant                     = '0;
                o_grant[w_cand[IDX_W-1:0]]  = 1'b1;
                o_idx                       = w_cand[IDX_W-1:0];
                o_valid                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// requesters: latch the granted byte, strobe Tx_WR, follow Tx_BUSY to the end
// of the frame, then rotate priority. Flags a transmitter that never accepts.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ACCEPT_TIMEOUT = DEFAULT_ACCEPT_TIMEOUT,
    parameter int TO_W           = 5,
    localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             Tx_DATA,
    output logic                   Tx_WR,
    output logic                   Tx_EN,
    input  logic                   Tx_BUSY,
    output logic                   frame_done,
    output logic [IDX_W-1:0]       active_id,
    output logic                   tx_timeout
);

    sched_state_t        r_state;
    sched_state_t        w_nextState;

    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_txData;
    logic [IDX_W-1:0]    r_activeId;
    logic [IDX_W-1:0]    r_ptr;
    logic [TO_W-1:0]     r_toCount;
    logic                r_frameDone;
    logic                r_txTimeout;

    logic [NUM_REQ-1:0]  w_arbGrant;
    logic [IDX_W-1:0]    w_arbIdx;
    logic                w_arbValid;
    logic [7:0]          w_selData;
    logic [IDX_W-1:0]    w_nextPtr;
    logic                w_takeGrant;
    logic                w_timeoutHit;
    logic                w_frameEnd;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arbGrant),
        .o_idx   (w_arbIdx),
        .o_valid (w_arbValid)
    );

    // Byte of whichever requester the arbiter is currently picking.
    always_comb begin
        w_selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arbGrant[i]) begin
                w_selData = req_data[8*i +: 8];
            end
        end
    end

    // Priority moves to the requester just after the one served, modulo NUM_REQ.
    always_comb begin
        if (r_activeId == IDX_W'(NUM_REQ - 1)) begin
            w_nextPtr = '0;
        end else begin
            w_nextPtr = r_activeId + IDX_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a started frame always runs to completion regardless of enable.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:        if (enable && w_arbValid) w_nextState = LOAD;
            LOAD:        w_nextState = WAIT_ACCEPT;
            WAIT_ACCEPT: begin
                if (Tx_BUSY) begin
                    w_nextState = WAIT_DONE;
                end else if (w_timeoutHit) begin
                    w_nextState = IDLE;
                end
            end
            WAIT_DONE:   if (!Tx_BUSY) w_nextState = IDLE;
            default:     w_nextState = IDLE;
        endcase
    end

    // Output/event decode from the current state.
    always_comb begin
        w_takeGrant  = (r_state == IDLE) && enable && w_arbValid;
        Tx_WR        = (r_state == LOAD);
        w_timeoutHit = (r_state == WAIT_ACCEPT) && !Tx_BUSY &&
                       (r_toCount == TO_W'(ACCEPT_TIMEOUT - 1));
        w_frameEnd   = (r_state == WAIT_DONE) && !Tx_BUSY;
    end

    // Datapath registers: grant pulse, latched byte, pointer, timeout counter and flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_grant     <= '0;
            r_txData    <= '0;
            r_activeId  <= '0;
            r_ptr       <= '0;
            r_toCount   <= '0;
            r_frameDone <= 1'b0;
            r_txTimeout <= 1'b0;
        end else begin
            r_grant     <= w_takeGrant ? w_arbGrant : '0;
            r_frameDone <= w_frameEnd;
            if (w_takeGrant) begin
                r_txData   <= w_selData;
                r_activeId <= w_arbIdx;
            end
            if (r_state == LOAD) begin
                r_toCount <= '0;
            end else if ((r_state == WAIT_ACCEPT) && !Tx_BUSY) begin
                r_toCount <= r_toCount + TO_W'(1);
            end
            if (w_timeoutHit) begin
                r_txTimeout <= 1'b1;
            end
            if (w_timeoutHit || w_frameEnd) begin
                r_ptr <= w_nextPtr;
            end
        end
    end

    assign Tx_EN      = enable;
    assign grant      = r_grant;
    assign Tx_DATA    = r_txData;
    assign active_id  = r_activeId;
    assign frame_done = r_frameDone;
    assign tx_timeout = r_txTimeout;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a simple transmitter model
// and a grant scoreboard.
module tb_uart_tx_scheduler;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  grant;
    logic [7:0]  Tx_DATA;
    logic        Tx_WR;
    logic        Tx_EN;
    logic        Tx_BUSY;
    logic        frame_done;
    logic [1:0]  active_id;
    logic        tx_timeout;

    int errors = 0;
    int checks = 0;
    int grantSeen = 0;
    int wrCount = 0;
    int doneCount = 0;

    logic busyModelOn;
    int   busyLen;
    int   busyCnt;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    uart_tx_scheduler #(
        .NUM_REQ        (4),
        .ACCEPT_TIMEOUT (16),
        .TO_W           (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .req_data   (reqData),
        .grant      (grant),
        .Tx_DATA    (Tx_DATA),
        .Tx_WR      (Tx_WR),
        .Tx_EN      (Tx_EN),
        .Tx_BUSY    (Tx_BUSY),
        .frame_done (frame_done),
        .active_id  (active_id),
        .tx_timeout (tx_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Transmitter model: busy for busyLen cycles starting the cycle after a write.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busyCnt <= 0;
        end else if (Tx_WR && busyModelOn) begin
            busyCnt <= busyLen;
        end else if (busyCnt > 0) begin
            busyCnt <= busyCnt - 1;
        end
    end
    assign Tx_BUSY = (busyCnt > 0);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: every grant pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (reset) begin
            if (|grant) begin
                grantSeen++;
                if (sb.size() == 0) begin
                    checkOutput("unexpectedGrant", {28'd0, grant}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("grantOneHot", {28'd0, grant}, 32'd1 << e.idx);
                    checkOutput("txData", {24'd0, Tx_DATA}, {24'd0, e.data});
                    checkOutput("activeId", {30'd0, active_id}, e.idx);
                end
            end
            if (Tx_WR) begin
                wrCount++;
                checkOutput("wrWhileBusy", {31'd0, Tx_BUSY}, 32'd0);
                checkOutput("wrWithGrant", {31'd0, |grant}, 32'd1);
            end
            if (frame_done) doneCount++;
        end
    end

    task automatic pushExp(input int idx);
        exp_t e;
        e.idx  = idx;
        e.data = reqData[8*idx +: 8];
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic en);
        req    = r;
        enable = en;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".grant"}, {28'd0, grant}, 32'd0);
        checkOutput({tag, ".txData"}, {24'd0, Tx_DATA}, 32'd0);
        checkOutput({tag, ".txWr"}, {31'd0, Tx_WR}, 32'd0);
        checkOutput({tag, ".frameDone"}, {31'd0, frame_done}, 32'd0);
        checkOutput({tag, ".activeId"}, {30'd0, active_id}, 32'd0);
        checkOutput({tag, ".txTimeout"}, {31'd0, tx_timeout}, 32'd0);
    endtask

    task automatic resetDut();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        checkResetValues("reset");
    endtask

    // Requesters drop their bit once granted.
    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (|grant) req = req & ~grant;
        end
    endtask

    task automatic waitGrant(input string tag);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            if (|grant) begin
                req = req & ~grant;
                got = 1;
            end
        end
        if (!got) checkOutput({tag, ".grantTimeout"}, 32'd0, 32'd1);
    endtask

    task automatic waitFrameDone(input string tag);
        bit got = 0;
        for (int i = 0; i < 120 && !got; i++) begin
            @(negedge clock);
            if (|grant) req = req & ~grant;
            if (frame_done) got = 1;
        end
        if (!got) checkOutput({tag, ".doneTimeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int g0;
        int w0;
        int d0;
        int gr;
        int t;
        bit hit;

        reset       = 1'b0;
        busyModelOn = 1'b1;
        busyLen     = 10;
        reqData     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        applyStimulus(4'b0000, 1'b0);

        // Disabled scheduler ignores requests, then serves them once enabled.
        resetDut();
        applyStimulus(4'b0011, 1'b0);
        g0 = grantSeen;
        w0 = wrCount;
        stepCycles(20);
        checkOutput("disabled.txEn", {31'd0, Tx_EN}, 32'd0);
        checkOutput("disabled.grants", grantSeen - g0, 32'd0);
        checkOutput("disabled.writes", wrCount - w0, 32'd0);
        pushExp(0);
        pushExp(1);
        applyStimulus(4'b0011, 1'b1);
        checkOutput("enabled.txEn", {31'd0, Tx_EN}, 32'd1);
        waitFrameDone("enabled.f0");
        waitFrameDone("enabled.f1");

        // Single request with a held byte that changes after the grant.
        resetDut();
        reqData = {8'hD3, 8'hA5, 8'hB1, 8'hA0};
        pushExp(2);
        applyStimulus(4'b0100, 1'b1);
        waitGrant("single");
        reqData[23:16] = 8'h5A;
        waitFrameDone("single");
        checkOutput("single.dataHeld", {24'd0, Tx_DATA}, 32'hA5);
        checkOutput("single.activeId", {30'd0, active_id}, 32'd2);
        @(negedge clock);
        checkOutput("single.donePulse", {31'd0, frame_done}, 32'd0);

        // Fairness: all four held for eight frames.
        resetDut();
        reqData = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int k = 0; k < 8; k++) pushExp(k % 4);
        w0 = wrCount;
        d0 = doneCount;
        gr = 0;
        hit = 0;
        applyStimulus(4'b1111, 1'b1);
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clock);
            if (|grant) begin
                gr++;
                if (gr == 8) req = 4'b0000;
            end
            if (frame_done && gr == 8) hit = 1;
        end
        checkOutput("fair.grants", gr, 32'd8);
        checkOutput("fair.writes", wrCount - w0, 32'd8);
        stepCycles(1);
        checkOutput("fair.frames", doneCount - d0, 32'd8);

        // Enable dropped mid-frame: frame completes, no further grants.
        resetDut();
        pushExp(2);
        applyStimulus(4'b0100, 1'b1);
        waitGrant("enDrop");
        stepCycles(3);
        enable = 1'b0;
        stepCycles(1);
        checkOutput("enDrop.txEn", {31'd0, Tx_EN}, 32'd0);
        waitFrameDone("enDrop");
        g0 = grantSeen;
        req = 4'b0001;
        stepCycles(20);
        checkOutput("enDrop.noGrant", grantSeen - g0, 32'd0);

        // Timeout: transmitter never goes busy.
        resetDut();
        busyModelOn = 1'b0;
        pushExp(0);
        applyStimulus(4'b0001, 1'b1);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clock);
            if (|grant) req = req & ~grant;
            if (Tx_WR) hit = 1;
        end
        checkOutput("timeout.sawWrite", {31'd0, hit}, 32'd1);
        t = 0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clock);
            t++;
            if (tx_timeout) hit = 1;
        end
        checkOutput("timeout.delay", t, 32'd17);
        busyModelOn = 1'b1;
        pushExp(1);
        pushExp(0);
        applyStimulus(4'b0011, 1'b1);
        waitFrameDone("timeout.next1");
        waitFrameDone("timeout.next0");
        checkOutput("timeout.sticky", {31'd0, tx_timeout}, 32'd1);

        // Asynchronous reset during WAIT_DONE.
        pushExp(2);
        applyStimulus(4'b0100, 1'b1);
        waitGrant("midReset");
        stepCycles(4);
        checkOutput("midReset.busyBefore", {31'd0, Tx_BUSY}, 32'd1);
        checkOutput("midReset.flagBefore", {31'd0, tx_timeout}, 32'd1);
        #2 reset = 1'b0;
        #1 checkResetValues("midReset");
        checkOutput("midReset.txEn", {31'd0, Tx_EN}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        pushExp(3);
        applyStimulus(4'b1000, 1'b1);
        waitFrameDone("afterReset");

        checkOutput("scoreboardEmpty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
